// File: rtl/ifir_interp_chain.sv
// Cascade of NSTAGES 2x linear interpolators driven by one shared phase counter.
// Define IFIR_TAP_EN to expose every stage output on tap_out.
module ifir_interp_chain #(
  parameter int W       = 24,
  parameter int NSTAGES = 4
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] data_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [W-1:0] data_out,
  output logic                out_valid,
  output logic                underrun,
  input  logic                underrun_clr
`ifdef IFIR_TAP_EN
  ,
  output logic [NSTAGES*W-1:0] tap_out
`endif
);

  localparam logic [NSTAGES-1:0] CNT_LAST = '1;

  logic [NSTAGES-1:0]  r_cnt;
  logic signed [W-1:0] r_hold;
  logic                r_outValid;
  logic                r_underrun;
  logic                w_accept;
  logic                w_miss;
  logic signed [W-1:0] w_y [0:NSTAGES];

  assign in_ready = en && (r_cnt == CNT_LAST) && !rst;
  assign w_accept = in_ready && in_valid;
  assign w_miss   = in_ready && !in_valid;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + NSTAGES'(1);
    end
  end

  // A missed slot keeps the previous sample so the chain repeats it.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_accept) begin
      r_hold <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_underrun <= 1'b0;
    end else if (w_miss) begin
      r_underrun <= 1'b1;
    end else if (en && underrun_clr) begin
      r_underrun <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= en;
    end
  end

  assign w_y[0]    = r_hold;
  assign data_out  = w_y[NSTAGES];
  assign out_valid = r_outValid;
  assign underrun  = r_underrun;

  generate
    for (genvar k = 1; k <= NSTAGES; k++) begin : g_stage
      // Stage k runs at 2^k times the input rate; its strobe masks the low counter bits.
      localparam logic [NSTAGES-1:0] STROBE_MASK = NSTAGES'((1 << (NSTAGES - k)) - 1);

      logic signed [W-1:0] r_a;
      logic signed [W-1:0] r_b;
      logic signed [W-1:0] r_y;
      logic signed [W:0]   w_sum;
      logic                w_strobe;
      logic                w_evenPhase;

      assign w_strobe    = en && ((r_cnt & STROBE_MASK) == STROBE_MASK);
      assign w_evenPhase = r_cnt[NSTAGES-k];
      assign w_sum       = {r_a[W-1], r_a} + {r_b[W-1], r_b};

      always_ff @(posedge clock) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
          r_y <= '0;
        end else if (w_strobe) begin
          if (w_evenPhase) begin
            r_a <= r_b;
            r_b <= w_y[k-1];
            r_y <= r_b;
          end else begin
            r_y <= W'(w_sum >>> 1);
          end
        end
      end

      assign w_y[k] = r_y;

`ifdef IFIR_TAP_EN
      assign tap_out[k*W-1 -: W] = r_y;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_ifir_interp_chain.sv
// Directed bench: vector table on a 1-stage chain, hand sequences on a 4-stage chain,
// and a tap check on a 2-stage chain when IFIR_TAP_EN is defined.
module tb_ifir_interp_chain;

  localparam int W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  logic enA, rstA, vldA, clrA, rdyA, ovA, urA;
  logic signed [W-1:0] dinA, doutA;
  logic enB, rstB, vldB, clrB, rdyB, ovB, urB;
  logic signed [W-1:0] dinB, doutB;
  logic enC, rstC, vldC, clrC, rdyC, ovC, urC;
  logic signed [W-1:0] dinC, doutC;
`ifdef IFIR_TAP_EN
  logic [2*W-1:0] tapC;
`endif

  ifir_interp_chain #(.W(W), .NSTAGES(1)) dutA (
    .clock(clk), .rst(rstA), .en(enA), .data_in(dinA), .in_valid(vldA),
    .in_ready(rdyA), .data_out(doutA), .out_valid(ovA), .underrun(urA),
    .underrun_clr(clrA)
`ifdef IFIR_TAP_EN
    , .tap_out()
`endif
  );

  ifir_interp_chain #(.W(W), .NSTAGES(4)) dutB (
    .clock(clk), .rst(rstB), .en(enB), .data_in(dinB), .in_valid(vldB),
    .in_ready(rdyB), .data_out(doutB), .out_valid(ovB), .underrun(urB),
    .underrun_clr(clrB)
`ifdef IFIR_TAP_EN
    , .tap_out()
`endif
  );

  ifir_interp_chain #(.W(W), .NSTAGES(2)) dutC (
    .clock(clk), .rst(rstC), .en(enC), .data_in(dinC), .in_valid(vldC),
    .in_ready(rdyC), .data_out(doutC), .out_valid(ovC), .underrun(urC),
    .underrun_clr(clrC)
`ifdef IFIR_TAP_EN
    , .tap_out(tapC)
`endif
  );

  typedef struct {
    logic                en;
    logic                rst;
    logic signed [W-1:0] din;
    logic                vld;
    logic                clr;
    logic                expRdy;
    logic signed [W-1:0] expOut;
    logic                expOv;
    logic                expUr;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic en, input logic rst, input int din, input logic vld,
                        input logic clr, input logic expRdy, input int expOut,
                        input logic expOv, input logic expUr);
    vec_t v;
    v.en = en; v.rst = rst; v.din = W'(din); v.vld = vld; v.clr = clr;
    v.expRdy = expRdy; v.expOut = W'(expOut); v.expOv = expOv; v.expUr = expUr;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    enA  = v.en;
    rstA = v.rst;
    dinA = v.din;
    vldA = v.vld;
    clrA = v.clr;
  endtask

  task automatic waitReadyB(output int edges);
    edges = 0;
    while (rdyB !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int edges;
    int acc;
    logic wasRdy;

    rstA = 1'b1; enA = 1'b0; dinA = '0; vldA = 1'b0; clrA = 1'b0;
    rstB = 1'b1; enB = 1'b0; dinB = '0; vldB = 1'b0; clrB = 1'b0;
    rstC = 1'b1; enC = 1'b0; dinC = '0; vldC = 1'b0; clrC = 1'b0;
    repeat (2) tick();

    // Fields: en, rst, din, vld, clr | in_ready before edge | data_out, out_valid, underrun after edge
    addVec(1, 0,    0, 1, 0,  0,    0, 1, 0);
    addVec(1, 0, 1000, 1, 0,  1,    0, 1, 0);
    addVec(1, 0, 1000, 1, 0,  0,    0, 1, 0);
    addVec(1, 0, 1000, 1, 0,  1,    0, 1, 0);
    addVec(1, 0, 1000, 1, 0,  0,  500, 1, 0);
    addVec(1, 0, 1000, 1, 0,  1, 1000, 1, 0);
    addVec(1, 0, 1000, 1, 0,  0, 1000, 1, 0);
    addVec(1, 0,   -7, 1, 0,  1, 1000, 1, 0);
    addVec(1, 0,   -7, 1, 0,  0, 1000, 1, 0);
    addVec(1, 0,   -7, 1, 0,  1, 1000, 1, 0);
    for (int g = 0; g < 7; g++) addVec(0, 0, -7, 1, 0,  0, 1000, 0, 0);
    addVec(1, 0,   -7, 1, 0,  0,  496, 1, 0);
    addVec(1, 0,   -7, 1, 0,  1,   -7, 1, 0);
    addVec(1, 0,    0, 1, 0,  0,   -7, 1, 0);
    addVec(1, 0,    0, 1, 0,  1,   -7, 1, 0);
    addVec(1, 0,    0, 1, 0,  0,   -7, 1, 0);
    addVec(1, 0,    0, 1, 0,  1,   -7, 1, 0);
    addVec(1, 0,    0, 1, 0,  0,   -4, 1, 0);
    addVec(1, 0,    0, 0, 0,  1,    0, 1, 1);
    addVec(1, 0,    0, 1, 1,  0,    0, 1, 0);
    addVec(1, 0,    0, 0, 1,  1,    0, 1, 1);
    addVec(1, 0,  300, 1, 0,  0,    0, 1, 1);
    addVec(1, 0,  300, 1, 0,  1,    0, 1, 1);
    addVec(1, 0,  300, 1, 0,  0,    0, 1, 1);
    addVec(1, 0,  300, 1, 0,  1,    0, 1, 1);
    addVec(1, 0,  300, 1, 0,  0,  150, 1, 1);
    addVec(1, 1,   77, 1, 0,  0,    0, 0, 0);
    addVec(1, 0,   77, 1, 0,  0,    0, 1, 0);
    addVec(1, 0,   77, 1, 0,  1,    0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("A%0d in_ready", i), rdyA, vecs[i].expRdy);
      tick();
      checkOutput($sformatf("A%0d data_out", i), doutA, vecs[i].expOut);
      checkOutput($sformatf("A%0d out_valid", i), ovA, vecs[i].expOv);
      checkOutput($sformatf("A%0d underrun", i), urA, vecs[i].expUr);
    end

    // Four-stage chain: reset release timing, then DC extremes.
    rstB = 1'b0; enB = 1'b1; vldB = 1'b1; dinB = -24'sd8388608;
    checkOutput("B in_ready at release", rdyB, 0);
    waitReadyB(edges);
    checkOutput("B first in_ready edges", edges, 15);
    repeat (200) tick();
    for (int i = 0; i < 32; i++) begin
      checkOutput("B dc min data_out", doutB, -64'sd8388608);
      checkOutput("B dc min out_valid", ovB, 1);
      tick();
    end
    dinB = 24'sd8388607;
    repeat (200) tick();
    for (int i = 0; i < 32; i++) begin
      checkOutput("B dc max data_out", doutB, 8388607);
      checkOutput("B dc max out_valid", ovB, 1);
      tick();
    end

    waitReadyB(edges);
    checkOutput("B slot found", rdyB, 1);
    vldB = 1'b0;
    tick();
    vldB = 1'b1;
    checkOutput("B underrun set", urB, 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      checkOutput("B repeat sample", doutB, 8388607);
    end
    waitReadyB(edges);
    tick();
    clrB = 1'b1;
    tick();
    clrB = 1'b0;
    checkOutput("B underrun cleared", urB, 0);
    waitReadyB(edges);
    vldB = 1'b0; clrB = 1'b1;
    tick();
    vldB = 1'b1; clrB = 1'b0;
    checkOutput("B set wins over clr", urB, 1);

    // Freeze for 7 cycles with the counter at 5, then resume.
    repeat (5) tick();
    enB = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput("B gap in_ready", rdyB, 0);
      checkOutput("B gap data_out", doutB, 8388607);
      checkOutput("B gap out_valid", ovB, 0);
    end
    enB = 1'b1;
    waitReadyB(edges);
    checkOutput("B resume edges to in_ready", edges, 10);
    checkOutput("B resume out_valid", ovB, 1);
    checkOutput("B resume data_out", doutB, 8388607);

    // Reset on a ready slot with the underrun flag and data path loaded.
    rstB = 1'b1;
    #1;
    checkOutput("B in_ready during rst", rdyB, 0);
    tick();
    checkOutput("B rst data_out", doutB, 0);
    checkOutput("B rst out_valid", ovB, 0);
    checkOutput("B rst underrun", urB, 0);
    checkOutput("B rst in_ready", rdyB, 0);
    rstB = 1'b0;
    waitReadyB(edges);
    checkOutput("B post-rst edges to in_ready", edges, 15);
    checkOutput("B post-rst data_out", doutB, 0);

    checkOutput("C reset data_out", doutC, 0);
    checkOutput("C reset out_valid", ovC, 0);
    checkOutput("C reset underrun", urC, 0);
    checkOutput("C reset in_ready", rdyC, 0);

`ifdef IFIR_TAP_EN
    // Ramp of +8 per input sample: stage 1 steps by 4 every second edge from edge 8 on.
    rstC = 1'b0; enC = 1'b1; vldC = 1'b1; acc = 0; dinC = 24'sd8;
    for (int n = 1; n <= 60; n++) begin
      wasRdy = rdyC;
      tick();
      if (wasRdy) begin
        acc++;
        dinC = W'(8 * (acc + 1));
      end
      if (n >= 8) begin
        checkOutput($sformatf("C%0d tap stage1", n), $signed(tapC[W-1:0]), 2 * ((n & ~1) - 8));
        checkOutput($sformatf("C%0d tap stage2", n), $signed(tapC[2*W-1:W]), doutC);
      end
    end
`else
    acc = 0;
    wasRdy = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
